kernel_ad_ctrl_pio: RTL and testbench
=====================================

Name: kernel_ad_ctrl_pio

Overview:
Parametrised Avalon-MM output PIO that drives ADC control lines (chip select, convert start, mode pins). It replaces the fixed 8-bit single-register output port. It adds atomic bit set/clear registers and a hardware-timed pulse engine that inverts selected bits for an exact number of clocks. It also provides sticky completion status with an optional interrupt. It sits on the kernel Avalon fabric as a zero-wait-state slave.

Parameters:
DATA_WIDTH, 8, width of out_port and data register (1..32)
RESET_VALUE, 0, value loaded into data register on reset (DATA_WIDTH bits)
CNT_WIDTH, 16, width of pulse length register and down-counter (1..32)

Ports:
clk  input  1  single clock for all logic
reset_n  input  1  asynchronous, active-low reset
address  input  3  register select
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data; only low bits used per register
readdata  output  32  combinational read data, zero-extended, zero for unmapped addresses
out_port  output  DATA_WIDTH  control lines to ADC
irq  output  1  level interrupt = done & irq_en

Behaviour:
- Write accepted when chipselect=1 and write_n=0. Takes effect at that clk edge. No wait states.
- Reads are combinational from current register state. Reads have no side effects.
- Register map:
  - 0 DATA, RW: data register.
  - 1 OUTSET, W: data |= writedata[DATA_WIDTH-1:0]. Reads 0.
  - 2 OUTCLR, W: data &= ~writedata[DATA_WIDTH-1:0]. Reads 0.
  - 3 PMASK, RW: pulse mask, DATA_WIDTH bits.
  - 4 PLEN, RW: pulse length, CNT_WIDTH bits.
  - 5 CTRL/STAT:
    - Write: bit0 START (self-clearing), bit1 DONE_CLR (write 1 clears done), bit2 irq_en (stored).
    - Read: bit0 busy, bit1 done, bit2 irq_en.
  - 6, 7: reserved. Writes ignored, read 0.
- out_port = data ^ (active_mask & {DATA_WIDTH{busy}}). Registered sources only; no combinational path from bus inputs.
- Pulse FSM has two states, IDLE and PULSE. busy=1 in PULSE.
  - IDLE -> PULSE on a START write:
    - active_mask <= PMASK.
    - cnt <= (PLEN==0 ? 1 : PLEN).
  - In PULSE, cnt decrements every clock.
    - When cnt==1 at an edge: -> IDLE, done <= 1, cnt <= 0.
  - The inverted level lasts exactly max(PLEN,1) clocks. It starts the cycle after the START edge.
  - PLEN all-ones gives 2^CNT_WIDTH-1 clocks. The counter never wraps.
- Boundary rules:
  - START while busy: ignored. No restart, no extension, done unaffected.
  - PMASK/PLEN writes while busy: stored, but the running pulse uses the latched active_mask and cnt. They apply to the next START only.
  - DATA/OUTSET/OUTCLR writes while busy: take effect the next cycle. The XOR still applies on top.
  - Pulse end and DONE_CLR in the same cycle: done ends at 1 (set wins).
  - START and DONE_CLR in the same write: done cleared, pulse starts.
  - START with PMASK=0: FSM runs normally and done sets; out_port is unchanged.
- Reset (asynchronous assert, any state including mid-pulse):
  - data=RESET_VALUE; PMASK=0, active_mask=0, PLEN=0, cnt=0.
  - State IDLE, busy=0, done=0, irq_en=0.
  - out_port=RESET_VALUE, irq=0, and a pulse in progress is aborted immediately.
- Widths: writes truncate to the register width; reads zero-extend to 32 bits.

Test Plan:
- Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5, irq=0, read addr5 = 0, read addr0 = 32'h000000A5.
- DATA=8'h0F, OUTSET 8'hC0, OUTCLR 8'h03 -> out_port 8'hCF, 8'hCC on successive cycles; read addr1/addr2 = 0.
- PMASK=8'h01, PLEN=3, DATA=8'h00, START -> out_port=8'h01 for exactly 3 clocks then 8'h00; busy=1 for 3 clocks; done=1 after; irq stays 0 (irq_en=0).
- PLEN=0, START with irq_en=1 -> 1-clock pulse, irq=1; write DONE_CLR -> irq=0 next cycle; DONE_CLR on the final pulse cycle -> done still 1.
- PLEN=10, START, then START again and PMASK/PLEN writes at cycle 4 -> pulse still ends at cycle 10 with the original mask; a new START then uses the new values.
- Assert reset_n mid-pulse at cycle 5 of PLEN=20 -> out_port returns to RESET_VALUE asynchronously; busy=0; no done after release.

Source files
------------

// File: rtl/kernel_ad_ctrl_pio.sv
// Avalon-MM output PIO for ADC control lines: data register with atomic set/clear,
// a timed pulse engine that inverts masked bits for an exact clock count, and sticky done/irq.
module kernel_ad_ctrl_pio #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } state_t;

    state_t                state_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [DATA_WIDTH-1:0] pmask_reg;
    logic [DATA_WIDTH-1:0] active_mask_reg;
    logic [CNT_WIDTH-1:0]  plen_reg;
    logic [CNT_WIDTH-1:0]  cnt_reg;
    logic                  done_reg;
    logic                  irq_en_reg;

    logic wr_en;
    logic wr_data, wr_set, wr_clr, wr_pmask, wr_plen, wr_ctrl;
    logic busy;
    logic unused_wdata;

    assign wr_en    = chipselect & ~write_n;
    assign wr_data  = wr_en && (address == 3'd0);
    assign wr_set   = wr_en && (address == 3'd1);
    assign wr_clr   = wr_en && (address == 3'd2);
    assign wr_pmask = wr_en && (address == 3'd3);
    assign wr_plen  = wr_en && (address == 3'd4);
    assign wr_ctrl  = wr_en && (address == 3'd5);

    assign busy         = (state_reg == PULSE);
    assign irq          = done_reg & irq_en_reg;
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= RESET_VALUE;
        end else if (wr_data) begin
            data_reg <= writedata[DATA_WIDTH-1:0];
        end else if (wr_set) begin
            data_reg <= data_reg | writedata[DATA_WIDTH-1:0];
        end else if (wr_clr) begin
            data_reg <= data_reg & ~writedata[DATA_WIDTH-1:0];
        end
    end

    // Mask and length are only sampled by START, so writes during a pulse affect the next one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pmask_reg <= '0;
            plen_reg  <= '0;
        end else begin
            if (wr_pmask) pmask_reg <= writedata[DATA_WIDTH-1:0];
            if (wr_plen)  plen_reg  <= writedata[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            active_mask_reg <= '0;
            cnt_reg         <= '0;
            done_reg        <= 1'b0;
            irq_en_reg      <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en_reg <= writedata[2];
            // Clear first so a pulse ending on the same edge still leaves done set.
            if (wr_ctrl && writedata[1]) done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (wr_ctrl && writedata[0]) begin
                        state_reg       <= PULSE;
                        active_mask_reg <= pmask_reg;
                        cnt_reg         <= (plen_reg == '0) ? CNT_WIDTH'(1) : plen_reg;
                    end
                end
                PULSE: begin
                    if (cnt_reg == CNT_WIDTH'(1)) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_WIDTH'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_out
            assign out_port[gi] = data_reg[gi] ^ (active_mask_reg[gi] & busy);
        end
    endgenerate

    always_comb begin
        readdata = '0;
        case (address)
            3'd0: readdata[DATA_WIDTH-1:0] = data_reg;
            3'd3: readdata[DATA_WIDTH-1:0] = pmask_reg;
            3'd4: readdata[CNT_WIDTH-1:0]  = plen_reg;
            3'd5: readdata[2:0]            = {irq_en_reg, done_reg, busy};
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_kernel_ad_ctrl_pio.sv
// Bench for kernel_ad_ctrl_pio: directed scenarios followed by random bus traffic,
// all checked against a pulse-countdown reference model.
module tb_kernel_ad_ctrl_pio;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        irq;

    int tests_run = 0;
    int tests_failed = 0;

    kernel_ad_ctrl_pio #(
        .DATA_WIDTH (8),
        .RESET_VALUE(8'hA5),
        .CNT_WIDTH  (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Reference model: number of inverted clocks still to come, plus register contents.
    int          m_rem;
    logic [7:0]  m_data, m_pmask, m_mask;
    logic [15:0] m_plen;
    bit          m_done, m_irq_en;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic void model_reset();
        m_rem = 0; m_data = 8'hA5; m_pmask = '0; m_mask = '0; m_plen = '0;
        m_done = 0; m_irq_en = 0;
    endfunction

    function automatic void model_edge(input bit wr, input logic [2:0] a, input logic [31:0] d);
        int nrem = m_rem;
        if (wr && a == 3'd5 && d[1]) m_done = 0;
        if (m_rem > 0) begin
            nrem = m_rem - 1;
            if (nrem == 0) m_done = 1;
        end else if (wr && a == 3'd5 && d[0]) begin
            nrem   = (m_plen == 0) ? 1 : int'(m_plen);
            m_mask = m_pmask;
        end
        if (wr) begin
            case (a)
                3'd0: m_data   = d[7:0];
                3'd1: m_data   = m_data | d[7:0];
                3'd2: m_data   = m_data & ~d[7:0];
                3'd3: m_pmask  = d[7:0];
                3'd4: m_plen   = d[15:0];
                3'd5: m_irq_en = d[2];
                default: ;
            endcase
        end
        m_rem = nrem;
    endfunction

    function automatic logic [7:0] m_out();
        return m_data ^ ((m_rem > 0) ? m_mask : 8'h00);
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return {24'h0, m_data};
            3'd3: return {24'h0, m_pmask};
            3'd4: return {16'h0, m_plen};
            3'd5: return {29'h0, m_irq_en, m_done, (m_rem > 0)};
            default: return 32'h0;
        endcase
    endfunction

    task automatic step(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
        chipselect = cs; write_n = wn; address = a; writedata = d;
        @(posedge clk);
        if (reset_n) model_edge(cs && !wn, a, d);
        #1;
        chipselect = 1'b0; write_n = 1'b1;
        chk("out_port", {24'h0, out_port}, {24'h0, m_out()});
        chk("irq", {31'h0, irq}, {31'h0, m_done & m_irq_en});
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        step(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        #1;
        chk($sformatf("read%0d", a), readdata, m_read(a));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 3'd0, 32'h0);
            rd(3'd5);
        end
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset_out", {24'h0, out_port}, 32'h0000_00A5);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        rd(3'd5);
        rd(3'd0);
        chk("reset_read0", readdata, 32'h0000_00A5);
        #12 reset_n = 1'b1;   // released between edges

        // Data register and atomic set/clear
        wr(3'd0, 32'h0F);
        wr(3'd1, 32'hFFFF_FFC0);
        chk("outset", {24'h0, out_port}, 32'hCF);
        wr(3'd2, 32'h03);
        chk("outclr", {24'h0, out_port}, 32'hCC);
        rd(3'd1);
        rd(3'd2);
        rd(3'd6);

        // 3-clock pulse on bit 0, irq disabled
        wr(3'd3, 32'h01);
        wr(3'd4, 32'h3);
        wr(3'd0, 32'h00);
        wr(3'd5, 32'h1);
        chk("pulse3_c1", {24'h0, out_port}, 32'h01);
        idle(2);
        chk("pulse3_c3", {24'h0, out_port}, 32'h01);
        idle(1);
        chk("pulse3_end", {24'h0, out_port}, 32'h00);
        chk("pulse3_irq", {31'h0, irq}, 32'h0);

        // Zero length gives one clock; irq enabled; clear, then clear on final pulse cycle
        wr(3'd4, 32'h0);
        wr(3'd5, 32'h5);
        chk("plen0_c1", {24'h0, out_port}, 32'h01);
        idle(1);
        chk("plen0_irq", {31'h0, irq}, 32'h1);
        wr(3'd5, 32'h6);
        chk("doneclr_irq", {31'h0, irq}, 32'h0);
        wr(3'd4, 32'h2);
        wr(3'd5, 32'h5);
        idle(1);
        wr(3'd5, 32'h6);
        chk("set_wins", {31'h0, irq}, 32'h1);
        rd(3'd5);
        wr(3'd5, 32'h7);      // start together with done clear
        rd(3'd5);
        idle(3);

        // Restart and reconfigure while busy are deferred
        wr(3'd3, 32'h80);
        wr(3'd4, 32'd10);
        wr(3'd5, 32'h1);
        idle(3);
        wr(3'd5, 32'h1);
        wr(3'd3, 32'h0F);
        wr(3'd4, 32'd2);
        wr(3'd1, 32'h10);
        chk("old_mask", {24'h0, out_port}, 32'h90);
        idle(4);
        chk("still_busy_end", {24'h0, out_port}, 32'h00 ^ 32'h10);
        wr(3'd5, 32'h1);
        chk("new_mask", {24'h0, out_port}, 32'h1F);
        idle(3);

        // Asynchronous reset mid-pulse
        wr(3'd4, 32'd20);
        wr(3'd3, 32'hFF);
        wr(3'd5, 32'h5);
        idle(4);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_out", {24'h0, out_port}, 32'hA5);
        rd(3'd5);
        #3 reset_n = 1'b1;
        idle(25);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [2:0]  a;
            logic [31:0] d;
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3'd4) d = $urandom_range(0, 12);
            if (a == 3'd5) d = $urandom_range(0, 7);
            step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 2) != 0), a, d);
            rd(3'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
